// File: rtl/text_console_if.sv
// Byte-stream and frame-buffer port bundle for text_console.
// The slave modport is the console side; the master is the producer plus frame buffer.
interface text_console_if;
   logic        iValid;
   logic [7:0]  iChar;
   logic        oReady;
   logic        oWriteEn;
   logic [31:0] oWAddr;
   logic [31:0] oWData;
   logic [31:0] oRAddr;
   logic [31:0] iRData;
   logic [6:0]  oCursorX;
   logic [4:0]  oCursorY;

   modport slave (
      input  iValid, iChar, iRData,
      output oReady, oWriteEn, oWAddr, oWData, oRAddr, oCursorX, oCursorY
   );

   modport master (
      output iValid, iChar, iRData,
      input  oReady, oWriteEn, oWAddr, oWData, oRAddr, oCursorX, oCursorY
   );
endinterface

// File: rtl/text_console.sv
// Character-stream front end for an 80x30 text frame buffer: cursor tracking, scroll and clear.
// Optional macro CONSOLE_CLEAR_ON_RESET_EN: clear the whole screen on reset release.
//
// state     | meaning
// IDLE      | ready for a byte
// PUT       | one busy cycle after an accepted byte (carries the character write, if any)
// SCROLL    | copy rows 1..ROWS-1 up one row, one word per cycle
// CLEAR_ROW | blank the last row
// CLEAR_ALL | blank the whole screen, then home the cursor
module text_console #(
   parameter int          COLS = 80,
   parameter int          ROWS = 30,
   parameter logic [23:0] ATTR = 24'hFFFFFF
) (
   input logic           iClk,
   input logic           iRst,
   text_console_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PUT, SCROLL, CLEAR_ROW, CLEAR_ALL} state_t;

   localparam logic [31:0] L_COLS  = 32'(COLS);
   localparam logic [31:0] L_TOTAL = 32'(COLS * ROWS);
   localparam logic [31:0] L_KEEP  = 32'(COLS * (ROWS - 1));
   localparam logic [6:0]  L_XMAX  = 7'(COLS - 1);
   localparam logic [4:0]  L_YMAX  = 5'(ROWS - 1);
   localparam logic [31:0] L_SPACE = {ATTR, 8'h20};

   state_t      r_state;
   logic [6:0]  r_x;
   logic [4:0]  r_y;
   logic        r_we;
   logic        r_scroll;
   logic [31:0] r_waddr;
   logic [31:0] r_wdata;
   logic [31:0] r_raddr;
   logic [31:0] r_cnt;

   logic [31:0] w_cur_addr;
   logic [7:0]  w_ch;
   logic        w_print;

   assign w_ch       = bus.iChar;
   assign w_cur_addr = 32'(r_y) * L_COLS + 32'(r_x);
   assign w_print    = (w_ch >= 8'h20) && (w_ch <= 8'h7E);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_x      <= '0;
         r_y      <= '0;
         r_we     <= 1'b0;
         r_scroll <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_raddr  <= '0;
         r_cnt    <= '0;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
         r_state  <= CLEAR_ALL;
`else
         r_state  <= IDLE;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_we <= 1'b0;
               if (bus.iValid) begin
                  r_state  <= PUT;
                  r_scroll <= 1'b0;
                  if (w_print) begin
                     r_we    <= 1'b1;
                     r_waddr <= w_cur_addr;
                     r_wdata <= {ATTR, w_ch};
                     if (r_x == L_XMAX) begin
                        r_x <= '0;
                        if (r_y == L_YMAX) r_scroll <= 1'b1;
                        else               r_y      <= r_y + 5'd1;
                     end else begin
                        r_x <= r_x + 7'd1;
                     end
                  end else begin
                     case (w_ch)
                        8'h0A: begin
                           r_x <= '0;
                           // Newline on the last row skips PUT so the scroll is exactly COLS*ROWS cycles
                           if (r_y == L_YMAX) begin
                              r_state <= SCROLL;
                              r_we    <= 1'b1;
                              r_waddr <= '0;
                              r_raddr <= L_COLS;
                              r_cnt   <= L_KEEP - 32'd1;
                           end else begin
                              r_y <= r_y + 5'd1;
                           end
                        end
                        8'h0D: r_x <= '0;
                        8'h08: begin
                           if (r_x != '0) begin
                              r_x     <= r_x - 7'd1;
                              r_we    <= 1'b1;
                              r_waddr <= w_cur_addr - 32'd1;
                              r_wdata <= L_SPACE;
                           end
                        end
                        8'h0C: begin
                           r_state <= CLEAR_ALL;
                           r_we    <= 1'b1;
                           r_waddr <= '0;
                           r_wdata <= L_SPACE;
                           r_cnt   <= L_TOTAL - 32'd1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            PUT: begin
               if (r_scroll) begin
                  r_state <= SCROLL;
                  r_we    <= 1'b1;
                  r_waddr <= '0;
                  r_raddr <= L_COLS;
                  r_cnt   <= L_KEEP - 32'd1;
               end else begin
                  r_state <= IDLE;
                  r_we    <= 1'b0;
               end
            end
            SCROLL: begin
               if (r_cnt == '0) begin
                  r_state <= CLEAR_ROW;
                  r_waddr <= L_KEEP;
                  r_wdata <= L_SPACE;
                  r_cnt   <= L_COLS - 32'd1;
               end else begin
                  r_waddr <= r_waddr + 32'd1;
                  r_raddr <= r_raddr + 32'd1;
                  r_cnt   <= r_cnt - 32'd1;
               end
            end
            CLEAR_ROW: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_we    <= 1'b0;
               end else begin
                  r_waddr <= r_waddr + 32'd1;
                  r_cnt   <= r_cnt - 32'd1;
               end
            end
            CLEAR_ALL: begin
               // Entered from reset the strobe is still low, so the sweep starts one cycle later
               if (!r_we) begin
                  r_we    <= 1'b1;
                  r_waddr <= '0;
                  r_wdata <= L_SPACE;
                  r_cnt   <= L_TOTAL - 32'd1;
               end else if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_we    <= 1'b0;
                  r_x     <= '0;
                  r_y     <= '0;
               end else begin
                  r_waddr <= r_waddr + 32'd1;
                  r_cnt   <= r_cnt - 32'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oReady   = (r_state == IDLE) && !iRst;
   assign bus.oWriteEn = r_we;
   assign bus.oWAddr   = r_waddr;
   assign bus.oWData   = (r_state == SCROLL) ? bus.iRData : r_wdata;
   assign bus.oRAddr   = r_raddr;
   assign bus.oCursorX = r_x;
   assign bus.oCursorY = r_y;
endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: screen-level model, expected-write queue, directed byte vectors.
module tb_text_console;
   localparam int          COLS  = 80;
   localparam int          ROWS  = 30;
   localparam int          TOTAL = COLS * ROWS;
   localparam int          LIM   = 6000;
   localparam logic [31:0] SP    = 32'hFFFFFF20;

   logic iClk = 1'b0;
   logic iRst = 1'b1;

   text_console_if bus ();

   text_console #(.COLS(COLS), .ROWS(ROWS), .ATTR(24'hFFFFFF)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] fb      [TOTAL];
   logic [31:0] ms_done [TOTAL];
   logic [31:0] fut     [TOTAL];
   int          mx = 0;
   int          my = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   assign bus.iRData = (bus.oRAddr < 32'(TOTAL)) ? fb[int'(bus.oRAddr)] : 32'hDEADBEEF;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Screen-level model: expected writes in order, plus the screen as it will look afterwards
   function automatic void push(input int a, input logic [31:0] d);
      wr_t e;
      e.a = 32'(a);
      e.d = d;
      exp_q.push_back(e);
      fut[a] = d;
   endfunction

   function automatic void model_newline();
      if (my < ROWS - 1) my++;
      else begin
         for (int k = 0; k < COLS * (ROWS - 1); k++) push(k, fut[k + COLS]);
         for (int a = COLS * (ROWS - 1); a < TOTAL; a++) push(a, SP);
      end
   endfunction

   function automatic void model_accept(input logic [7:0] ch);
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         push(my * COLS + mx, {24'hFFFFFF, ch});
         mx++;
         if (mx == COLS) begin
            mx = 0;
            model_newline();
         end
      end else if (ch == 8'h0A) begin
         mx = 0;
         model_newline();
      end else if (ch == 8'h0D) begin
         mx = 0;
      end else if (ch == 8'h08) begin
         if (mx > 0) begin
            mx--;
            push(my * COLS + mx, SP);
         end
      end else if (ch == 8'h0C) begin
         for (int a = 0; a < TOTAL; a++) push(a, SP);
         mx = 0;
         my = 0;
      end
   endfunction

   // Frame buffer: initial banner pattern, written by the DUT
   initial begin
      for (int i = 0; i < TOTAL; i++) fb[i] = 32'h5A000000 | 32'(i);
      forever begin
         @(posedge iClk);
         if (bus.oWriteEn && bus.oWAddr < 32'(TOTAL)) fb[int'(bus.oWAddr)] = bus.oWData;
      end
   end

   // Compare process: every write against the model, cursor and strobe whenever idle
   initial begin
      wr_t e;
      for (int i = 0; i < TOTAL; i++) ms_done[i] = 32'h5A000000 | 32'(i);
      forever begin
         @(posedge iClk);
         #1;
         if (!iRst) begin
            if (bus.oWriteEn) begin
               chk("write_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("waddr", bus.oWAddr, e.a);
                  chk("wdata", bus.oWData, e.d);
                  if (e.a < 32'(TOTAL)) ms_done[int'(e.a)] = e.d;
               end
            end
            if (bus.oReady) begin
               chk("we_in_idle", 32'(bus.oWriteEn), 0);
               chk("cursor_x", 32'(bus.oCursorX), 32'(mx));
               chk("cursor_y", 32'(bus.oCursorY), 32'(my));
            end
         end
      end
   end

   task automatic wait_ready(output int busy);
      busy = 0;
      #1;
      while (!bus.oReady && busy < LIM) begin
         busy++;
         @(negedge iClk);
         #1;
      end
      if (busy >= LIM) chk("ready_timeout", 32'(busy), 0);
   endtask

   task automatic send_accept(input logic [7:0] ch);
      int guard = 0;
      bus.iChar  = ch;
      bus.iValid = 1'b1;
      #1;
      while (!bus.oReady && guard < LIM) begin
         @(negedge iClk);
         #1;
         guard++;
      end
      if (guard >= LIM) chk("accept_timeout", 32'(guard), 0);
      @(posedge iClk);
      model_accept(ch);
      @(negedge iClk);
      bus.iValid = 1'b0;
   endtask

   task automatic send(input logic [7:0] ch, output int busy);
      send_accept(ch);
      wait_ready(busy);
   endtask

   task automatic send_n(input logic [7:0] ch, input int n);
      int b;
      for (int i = 0; i < n; i++) send(ch, b);
   endtask

   // Called at a falling edge; the reset is held across one rising edge
   task automatic do_reset();
      int busy;
      iRst       = 1'b1;
      bus.iValid = 1'b0;
      #1;
      chk("ready_in_reset", 32'(bus.oReady), 0);
      @(posedge iClk);
      exp_q.delete();
      fut = ms_done;
      mx  = 0;
      my  = 0;
`ifdef CONSOLE_CLEAR_ON_RESET_EN
      for (int a = 0; a < TOTAL; a++) push(a, SP);
`endif
      @(negedge iClk);
      chk("rst_we", 32'(bus.oWriteEn), 0);
      chk("rst_waddr", bus.oWAddr, 0);
      chk("rst_wdata", bus.oWData, 0);
      chk("rst_raddr", bus.oRAddr, 0);
      chk("rst_x", 32'(bus.oCursorX), 0);
      chk("rst_y", 32'(bus.oCursorY), 0);
      iRst = 1'b0;
      wait_ready(busy);
`ifdef CONSOLE_CLEAR_ON_RESET_EN
      chk("rst_busy", 32'(busy), 2401);
`else
      chk("rst_busy", 32'(busy), 0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      int g;
      int nmis;
      for (int i = 0; i < TOTAL; i++) fut[i] = 32'h5A000000 | 32'(i);
      bus.iValid = 1'b0;
      bus.iChar  = 8'h00;
      @(negedge iClk);
      do_reset();

      // Single printable byte
      send_accept(8'h48);
      chk("t1_we", 32'(bus.oWriteEn), 1);
      chk("t1_waddr", bus.oWAddr, 0);
      chk("t1_wdata", bus.oWData, 32'hFFFFFF48);
      chk("t1_x", 32'(bus.oCursorX), 1);
      chk("t1_y", 32'(bus.oCursorY), 0);
      wait_ready(busy);
      chk("t1_busy", 32'(busy), 1);
      send(8'h0D, busy);
      chk("cr_busy", 32'(busy), 1);

      // Full row wraps to the next row without scrolling
      send_n(8'h41, COLS);
      chk("t2_x", 32'(bus.oCursorX), 0);
      chk("t2_y", 32'(bus.oCursorY), 1);

      // Backspace with and without room to the left
      send(8'h0A, busy);
      for (int c = 0; c < 5; c++) send(8'(8'h61 + c), busy);
      send_accept(8'h08);
      chk("t3_we", 32'(bus.oWriteEn), 1);
      chk("t3_waddr", bus.oWAddr, 164);
      chk("t3_wdata", bus.oWData, 32'hFFFFFF20);
      chk("t3_x", 32'(bus.oCursorX), 4);
      chk("t3_y", 32'(bus.oCursorY), 2);
      wait_ready(busy);
      send(8'h0D, busy);
      send_accept(8'h08);
      chk("t3b_we", 32'(bus.oWriteEn), 0);
      chk("t3b_x", 32'(bus.oCursorX), 0);
      chk("t3b_y", 32'(bus.oCursorY), 2);
      wait_ready(busy);
      chk("t3b_busy", 32'(busy), 1);

      // Printable range edges and ignored bytes
      send(8'h20, busy);
      send(8'h7E, busy);
      send(8'h7F, busy);
      chk("del_busy", 32'(busy), 1);
      send(8'h1F, busy);
      chk("edge_x", 32'(bus.oCursorX), 2);

      // Newline on the last row scrolls
      send(8'h0D, busy);
      send_n(8'h0A, 27);
      send_n(8'h78, 10);
      chk("t4_pre_x", 32'(bus.oCursorX), 10);
      chk("t4_pre_y", 32'(bus.oCursorY), 29);
      send_accept(8'h0A);
      chk("t4_we", 32'(bus.oWriteEn), 1);
      chk("t4_waddr", bus.oWAddr, 0);
      chk("t4_raddr", bus.oRAddr, 80);
      chk("t4_wdata", bus.oWData, 32'h5A000050);
      wait_ready(busy);
      chk("t4_busy", 32'(busy), 2400);
      chk("t4_x", 32'(bus.oCursorX), 0);
      chk("t4_y", 32'(bus.oCursorY), 29);

      // Column wrap on the last row: write, then scroll
      send_n(8'h71, COLS - 1);
      send(8'h71, busy);
      chk("wrap_scroll_busy", 32'(busy), 2401);
      chk("wrap_scroll_y", 32'(bus.oCursorY), 29);

      // Form feed
      send_accept(8'h0C);
      chk("t5_waddr", bus.oWAddr, 0);
      chk("t5_wdata", bus.oWData, 32'hFFFFFF20);
      wait_ready(busy);
      chk("t5_busy", 32'(busy), 2400);
      chk("t5_x", 32'(bus.oCursorX), 0);
      chk("t5_y", 32'(bus.oCursorY), 0);

      // Reset in the middle of a scroll
      send_n(8'h0A, ROWS - 1);
      send_accept(8'h0A);
      g = 0;
      while (!(bus.oWriteEn && bus.oWAddr == 32'd1000) && g < LIM) begin
         @(negedge iClk);
         g++;
      end
      chk("t6_reached_k1000", 32'(g < LIM), 1);
      do_reset();
      send_accept(8'h5A);
      chk("t6_waddr", bus.oWAddr, 0);
      chk("t6_wdata", bus.oWData, 32'hFFFFFF5A);
      wait_ready(busy);

      repeat (3) @(negedge iClk);
      chk("pending_writes", 32'(exp_q.size()), 0);
      nmis = 0;
      for (int i = 0; i < TOTAL; i++) if (fb[i] !== ms_done[i]) nmis++;
      chk("fb_contents", 32'(nmis), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
